// File: rtl/rf_pkg.sv
// Shared register-file writeback types and constants.
// Holds the register address/data widths and the queued write request record.
package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  // One pending register-file write: destination register and its data.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // Returns a one-hot register mask for rd, or all zeros when disabled or rd is x0.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd,
                                                     input logic                  en);
    logic [NUM_REGS-1:0] vec;
    vec = '0;
    if (en && (rd != '0)) begin
      vec[rd] = 1'b1;
    end
    return vec;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Load-response FIFO for the writeback stage.
// Stores wb_req_t entries using wrap-around read/write pointers and an explicit occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  wb_req_t          push_req_i,
  input  logic             pop_i,
  output wb_req_t          head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pushOk;
  logic             popOk;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];

  assign pushOk = push_i && !full_o;
  assign popOk  = pop_i && !empty_o;

  // Advance pointers and occupancy; a push and pop together leave the count unchanged.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushOk) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (popOk) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    if (pushOk && !popOk) begin
      count_d = count_q + CNT_W'(1);
    end else if (popOk && !pushOk) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and count registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset because only counted entries are ever read as valid.
  always_ff @(posedge clk) begin
    if (pushOk) begin
      mem_q[wrPtr_q] <= push_req_i;
    end
  end

endmodule

// File: rtl/rf_writeback.sv
// Register-file writeback arbiter with a load-response queue and pending-load scoreboard.
// ALU results take priority; queued loads fill the slots the ALU leaves idle.
// Optional feature macro RF_WB_FWD_EN adds write-port forwarding hit detection.
module rf_writeback
  import rf_pkg::*;
#(
  parameter int LQ_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  ld_valid,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
`ifdef RF_WB_FWD_EN
  input  logic [REG_ADDR_W-1:0] fwd_a1,
  input  logic [REG_ADDR_W-1:0] fwd_a2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
`endif
  output logic                  ld_ready,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [XLEN-1:0]       wb_data,
  output logic [NUM_REGS-1:0]   busy
);

  localparam int CNT_W = $clog2(LQ_DEPTH + 1);

  wb_req_t               lqHead;
  wb_req_t               lqPushReq;
  logic                  lqFull;
  logic                  lqEmpty;
  logic [CNT_W-1:0]      lqCount;
  logic                  lqPush;
  logic                  lqPop;
  logic                  aluSel;
  logic                  ldWrite;

  logic                  wbWe_q, wbWe_d;
  logic [REG_ADDR_W-1:0] wbAddr_q, wbAddr_d;
  logic [XLEN-1:0]       wbData_q, wbData_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;

  // Readiness comes only from registered occupancy, so it never depends on this cycle's ALU traffic.
  assign ld_ready  = (lqCount < CNT_W'(LQ_DEPTH));
  assign lqPush    = ld_valid && ld_ready && !lqFull;
  assign lqPushReq = '{rd: ld_rd, data: ld_data};

  // ALU writes to x0 are dropped and free the slot; the queue head is consumed whenever the ALU is not writing.
  assign aluSel  = alu_valid && (alu_rd != '0);
  assign lqPop   = !aluSel && !lqEmpty;
  assign ldWrite = lqPop && (lqHead.rd != '0);

  rf_wb_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (lqPush),
    .push_req_i (lqPushReq),
    .pop_i      (lqPop),
    .head_o     (lqHead),
    .full_o     (lqFull),
    .empty_o    (lqEmpty),
    .count_o    (lqCount)
  );

  // Select the next write; address and data hold their previous values when nothing is written.
  always_comb begin
    wbWe_d   = 1'b0;
    wbAddr_d = wbAddr_q;
    wbData_d = wbData_q;
    if (aluSel) begin
      wbWe_d   = 1'b1;
      wbAddr_d = alu_rd;
      wbData_d = alu_data;
    end else if (ldWrite) begin
      wbWe_d   = 1'b1;
      wbAddr_d = lqHead.rd;
      wbData_d = lqHead.data;
    end
  end

  // Scoreboard update: clear the register whose load is selected, then set newly issued ones so a set wins.
  always_comb begin
    busy_d = (busy_q & ~reg_onehot(lqHead.rd, lqPop)) | reg_onehot(issue_rd, issue_valid);
    busy_d[0] = 1'b0;
  end

  // Writeback port and scoreboard registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbWe_q   <= 1'b0;
      wbAddr_q <= '0;
      wbData_q <= '0;
      busy_q   <= '0;
    end else begin
      wbWe_q   <= wbWe_d;
      wbAddr_q <= wbAddr_d;
      wbData_q <= wbData_d;
      busy_q   <= busy_d;
    end
  end

  assign wb_we   = wbWe_q;
  assign wb_addr = wbAddr_q;
  assign wb_data = wbData_q;
  assign busy    = busy_q;

`ifdef RF_WB_FWD_EN
  // A consumer reading the register being written this cycle should take wb_data instead of the stale array value.
  assign fwd_hit1 = wbWe_q && (wbAddr_q == fwd_a1) && (fwd_a1 != '0);
  assign fwd_hit2 = wbWe_q && (wbAddr_q == fwd_a2) && (fwd_a2 != '0);
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// Testbench for rf_writeback: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_rf_writeback;

  localparam int LQ_DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] busy;
`ifdef RF_WB_FWD_EN
  logic [4:0]  fwd_a1;
  logic [4:0]  fwd_a2;
  logic        fwd_hit1;
  logic        fwd_hit2;
`endif

  ent_t        mq[$];
  logic        mWe;
  logic [4:0]  mAddr;
  logic [31:0] mData;
  logic [31:0] mBusy;

  int checks = 0;
  int errors = 0;

  rf_writeback #(
    .LQ_DEPTH (LQ_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .ld_valid    (ld_valid),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
`ifdef RF_WB_FWD_EN
    .fwd_a1      (fwd_a1),
    .fwd_a2      (fwd_a2),
    .fwd_hit1    (fwd_hit1),
    .fwd_hit2    (fwd_hit2),
`endif
    .ld_ready    (ld_ready),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Return all stimulus inputs to their quiet values.
  task automatic idle();
    alu_valid   = 1'b0;
    alu_rd      = '0;
    alu_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    ld_valid    = 1'b0;
    ld_rd       = '0;
    ld_data     = '0;
  endtask

  // Advance the model by one cycle with the current inputs, then clock the DUT and settle.
  task automatic applyStimulus();
    bit   ready;
    bit   aluSel;
    ent_t e;
    ready  = (mq.size() < LQ_DEPTH);
    aluSel = alu_valid && (alu_rd != 0);
    if (!rst_n) begin
      mq.delete();
      mWe   = 1'b0;
      mAddr = '0;
      mData = '0;
      mBusy = '0;
    end else begin
      if (aluSel) begin
        mWe   = 1'b1;
        mAddr = alu_rd;
        mData = alu_data;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        mBusy[e.rd] = 1'b0;
        mWe = (e.rd != 0);
        if (e.rd != 0) begin
          mAddr = e.rd;
          mData = e.data;
        end
      end else begin
        mWe = 1'b0;
      end
      if (ld_valid && ready) mq.push_back('{rd: ld_rd, data: ld_data});
      if (issue_valid) mBusy[issue_rd] = 1'b1;
      mBusy[0] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    applyStimulus();
    applyStimulus();
    checks++; if (wb_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %b want 0", wb_we); end
    checks++; if (wb_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_addr got %0d want 0", wb_addr); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_data got %h want 0", wb_data); end
    checks++; if (busy !== 32'd0) begin errors++; $display("[TB] FAIL reset_busy got %h want 0", busy); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", ld_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_alu_write();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    applyStimulus();
    checks++; if (wb_we !== 1'b1 || wb_addr !== 5'd5 || wb_data !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL alu_write got we=%b addr=%0d data=%h want 1/5/deadbeef", wb_we, wb_addr, wb_data);
    end
    idle();
    applyStimulus();
    checks++; if (wb_we !== 1'b0 || wb_addr !== 5'd5 || wb_data !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL alu_hold got we=%b addr=%0d data=%h want 0/5/deadbeef", wb_we, wb_addr, wb_data);
    end
  endtask

  task automatic test_load();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd7;
    applyStimulus();
    checks++; if (busy[7] !== 1'b1) begin errors++; $display("[TB] FAIL load_busy_set got %b want 1", busy[7]); end
    idle();
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h12345678;
    applyStimulus();
    checks++; if (wb_we !== 1'b0 || busy[7] !== 1'b1) begin
      errors++; $display("[TB] FAIL load_enq got we=%b busy7=%b want 0/1", wb_we, busy[7]);
    end
    idle();
    applyStimulus();
    checks++; if (wb_we !== 1'b1 || wb_addr !== 5'd7 || wb_data !== 32'h12345678 || busy[7] !== 1'b0) begin
      errors++; $display("[TB] FAIL load_write got we=%b addr=%0d data=%h busy7=%b want 1/7/12345678/0",
                         wb_we, wb_addr, wb_data, busy[7]);
    end
    applyStimulus();
    checks++; if (wb_we !== 1'b0) begin errors++; $display("[TB] FAIL load_single got we=%b want 0", wb_we); end
  endtask

  task automatic test_fill();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd10;
    for (int i = 0; i < 4; i++) begin
      alu_data = 32'hC000_0000 + i;
      ld_valid = 1'b1; ld_rd = 5'(11 + i); ld_data = 32'hA000_0000 + i;
      applyStimulus();
      checks++; if (wb_we !== 1'b1 || wb_addr !== 5'd10 || wb_data !== 32'hC000_0000 + i) begin
        errors++; $display("[TB] FAIL fill_alu%0d got we=%b addr=%0d data=%h", i, wb_we, wb_addr, wb_data);
      end
    end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_ready got %b want 0", ld_ready); end
    ld_rd = 5'd15; ld_data = 32'hBAD0_BAD0;
    applyStimulus();
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_full_hold got %b want 0", ld_ready); end
    idle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checks++; if (wb_we !== 1'b1 || wb_addr !== 5'(11 + i) || wb_data !== 32'hA000_0000 + i) begin
        errors++; $display("[TB] FAIL drain%0d got we=%b addr=%0d data=%h want 1/%0d/%h",
                           i, wb_we, wb_addr, wb_data, 11 + i, 32'hA000_0000 + i);
      end
    end
    applyStimulus();
    checks++; if (wb_we !== 1'b0 || ld_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL drain_end got we=%b ready=%b want 0/1", wb_we, ld_ready);
    end
  endtask

  task automatic test_zero();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1111_1111;
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h2222_2222;
    issue_valid = 1'b1; issue_rd = 5'd0;
    applyStimulus();
    checks++; if (wb_we !== 1'b0 || busy[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_alu got we=%b busy0=%b want 0/0", wb_we, busy[0]);
    end
    idle();
    applyStimulus();
    checks++; if (wb_we !== 1'b0 || busy[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_load got we=%b busy0=%b want 0/0", wb_we, busy[0]);
    end
    applyStimulus();
    checks++; if (wb_we !== 1'b0 || ld_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL zero_consumed got we=%b ready=%b want 0/1", wb_we, ld_ready);
    end
  endtask

  task automatic test_back_to_back_busy();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd3;
    applyStimulus();
    idle();
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h0000_0033;
    applyStimulus();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd3;
    applyStimulus();
    checks++; if (wb_we !== 1'b1 || wb_addr !== 5'd3 || busy[3] !== 1'b1) begin
      errors++; $display("[TB] FAIL busy_overlap got we=%b addr=%0d busy3=%b want 1/3/1", wb_we, wb_addr, busy[3]);
    end
    idle();
    applyStimulus();
    checks++; if (busy[3] !== 1'b1) begin errors++; $display("[TB] FAIL busy_overlap_hold got %b want 1", busy[3]); end
  endtask

  task automatic test_reset_mid();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h5555_0000;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(20 + i);
      ld_valid = 1'b1; ld_rd = 5'(20 + i); ld_data = 32'h7700_0000 + i;
      applyStimulus();
    end
    checks++; if (busy[22:20] !== 3'b111 || ld_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_setup got busy=%b ready=%b want 111/1", busy[22:20], ld_ready);
    end
    idle();
    rst_n = 1'b0;
    applyStimulus();
    checks++; if (wb_we !== 1'b0 || wb_addr !== 5'd0 || wb_data !== 32'd0 || busy !== 32'd0 || ld_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_reset got we=%b addr=%0d data=%h busy=%h ready=%b want all zero, ready 1",
                         wb_we, wb_addr, wb_data, busy, ld_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checks++; if (wb_we !== 1'b0) begin errors++; $display("[TB] FAIL mid_after%0d got we=%b want 0", i, wb_we); end
    end
  endtask

  task automatic test_fwd();
`ifdef RF_WB_FWD_EN
    idle();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0909_0909;
    applyStimulus();
    fwd_a1 = 5'd9; fwd_a2 = 5'd8;
    #1;
    checks++; if (fwd_hit1 !== 1'b1 || fwd_hit2 !== 1'b0) begin
      errors++; $display("[TB] FAIL fwd_hit got h1=%b h2=%b want 1/0", fwd_hit1, fwd_hit2);
    end
    idle();
    applyStimulus();
    checks++; if (fwd_hit1 !== 1'b0) begin errors++; $display("[TB] FAIL fwd_idle got h1=%b want 0", fwd_hit1); end
`endif
  endtask

  task automatic test_random();
    int aluBias;
    for (int i = 0; i < 400; i++) begin
      rst_n       = ($urandom_range(0, 99) != 0);
      aluBias     = ((i / 50) % 2 == 1) ? 85 : 20;
      alu_valid   = ($urandom_range(0, 99) < aluBias);
      alu_rd      = 5'($urandom_range(0, 7));
      alu_data    = $urandom;
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 7));
      ld_valid    = ($urandom_range(0, 99) < 60);
      ld_rd       = 5'($urandom_range(0, 7));
      ld_data     = $urandom;
      applyStimulus();
      checks++; if (wb_we !== mWe) begin errors++; $display("[TB] FAIL rnd_we cyc %0d got %b want %b", i, wb_we, mWe); end
      checks++; if (wb_addr !== mAddr) begin errors++; $display("[TB] FAIL rnd_addr cyc %0d got %0d want %0d", i, wb_addr, mAddr); end
      checks++; if (wb_data !== mData) begin errors++; $display("[TB] FAIL rnd_data cyc %0d got %h want %h", i, wb_data, mData); end
      checks++; if (busy !== mBusy) begin errors++; $display("[TB] FAIL rnd_busy cyc %0d got %h want %h", i, busy, mBusy); end
      checks++; if (ld_ready !== (mq.size() < LQ_DEPTH)) begin
        errors++; $display("[TB] FAIL rnd_ready cyc %0d got %b want %b", i, ld_ready, mq.size() < LQ_DEPTH);
      end
    end
    rst_n = 1'b1;
    idle();
  endtask

  // Run every scenario in order, then report the totals.
  initial begin
    rst_n = 1'b0;
    idle();
`ifdef RF_WB_FWD_EN
    fwd_a1 = '0;
    fwd_a2 = '0;
`endif
    test_reset();
    test_alu_write();
    test_load();
    test_fill();
    test_zero();
    test_back_to_back_busy();
    test_reset_mid();
    test_fwd();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_writeback.md
RF_WRITEBACK -- requirements
Module: rf_writeback

Interface
REQ-001 Parameter LQ_DEPTH, default 4, load-response queue depth; power of two, minimum 2.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 alu_valid  input  1  ALU result present this cycle.
REQ-005 alu_rd  input  5  ALU destination register.
REQ-006 alu_data  input  32  ALU result.
REQ-007 issue_valid  input  1  load issued this cycle; marks issue_rd pending.
REQ-008 issue_rd  input  5  destination register of the issued load.
REQ-009 ld_valid  input  1  load response present this cycle.
REQ-010 ld_rd  input  5  load response destination register.
REQ-011 ld_data  input  32  load response data.
REQ-012 ld_ready  output  1  queue can accept a load response; high when occupancy < LQ_DEPTH.
REQ-013 wb_we  output  1  register-file write enable; connects to the register-file write-enable port.
REQ-014 wb_addr  output  5  register-file write address.
REQ-015 wb_data  output  32  register-file write data.
REQ-016 busy  output  32  scoreboard; bit n high means a load to register n is outstanding.

Function
REQ-017 wb_we, wb_addr and wb_data shall be registered; a write selected in cycle N appears on them in cycle N+1 for exactly one cycle.
REQ-018 ALU results shall have priority: alu_valid with alu_rd != 0 selects the ALU write, giving 1-cycle latency.
REQ-019 alu_valid with alu_rd == 0 shall be dropped, and that cycle's slot is free for a queued load.
REQ-020 A load response shall be enqueued when ld_valid && ld_ready; when ld_valid && !ld_ready it shall be ignored (protocol violation, not stored).
REQ-021 The queue head shall be dequeued and selected only when no ALU write is selected that cycle; minimum load latency is 2 cycles (enqueue, then dequeue/select).
REQ-022 A dequeued entry with rd == 0 shall be consumed without asserting wb_we.
REQ-023 The queue shall be FIFO with wrap-around pointers and an explicit count.
REQ-024 Simultaneous enqueue and dequeue shall leave occupancy unchanged, including at full.
REQ-025 ld_ready shall depend on registered occupancy only, never on alu_valid.
REQ-026 issue_valid with issue_rd != 0 shall set busy[issue_rd] at the next edge.
REQ-027 busy[rd] shall clear at the edge where that rd's load write is selected.
REQ-028 Simultaneous set and clear of the same bit shall leave it set.
REQ-029 busy[0] shall always read 0.
REQ-030 With nothing selected, wb_we shall be 0; wb_addr and wb_data shall hold their previous values.

Reset
REQ-031 While rst_n is low at a rising edge: wb_we=0, wb_addr=0, wb_data=0, busy=0, queue emptied (count=0, pointers=0), ld_ready=1 from the following cycle.
REQ-032 Reset mid-operation shall discard all queued loads and pending busy bits, with no write emitted.

Configuration
REQ-033 Macro RF_WB_FWD_EN, when defined, shall add inputs fwd_a1 and fwd_a2 (5 bits each) and outputs fwd_hit1 and fwd_hit2 (1 bit each).
REQ-034 With RF_WB_FWD_EN defined, fwd_hitK shall be high when wb_we && wb_addr == fwd_aK && fwd_aK != 0; this is combinational and lets the consumer substitute wb_data for a stale registered read.
REQ-035 Without RF_WB_FWD_EN, these ports and logic shall be absent and all other behaviour identical.

Structure
REQ-036 A shared package rf_pkg shall hold REG_ADDR_W=5, XLEN=32, NUM_REGS=32 and typedef wb_req_t {rd, data}.
REQ-037 The load queue shall be sub-module rf_wb_fifo, parameterised by depth and carrying wb_req_t, with push/pop/full/empty/count.

Verification
REQ-038 Test 1: ALU write x5=0xDEADBEEF at cycle N -> wb_we=1, wb_addr=5, wb_data=0xDEADBEEF at N+1 only.
REQ-039 Test 2: load to x7 with data 0x12345678 and no ALU traffic -> write at enqueue+2; busy[7] set after issue and cleared when the write is selected.
REQ-040 Test 3: fill 4 loads while alu_valid is held high to nonzero rd -> ld_ready=0; a 5th ld_valid is dropped; releasing the ALU drains 4 writes in order on consecutive cycles.
REQ-041 Test 4: ALU and load writes to x0 -> wb_we never asserted; busy[0]=0 throughout.
REQ-042 Test 5: issue to x3 in the same cycle its earlier load is selected -> busy[3] remains 1.
REQ-043 Test 6: rst_n low with 3 queued loads and busy bits set -> outputs zero, ld_ready=1, no writes after release; with RF_WB_FWD_EN, fwd_a1=wb_addr=9 with wb_we=1 -> fwd_hit1=1.
